// File: rtl/rob_ctrl_pkg.sv
// Shared ROB control types: retirement FSM state encoding and default flush length.
// Also used by the ROB and map-table benches, so keep it free of block-specific logic.
package rob_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2,
        HALTED  = 2'd3
    } retire_st_e;

    localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/rob_retire_stats.sv
// Free-running retirement statistics counters; all wrap modulo 2^CNT_W.
// Only instantiated by rob_retire_ctrl when RETIRE_STATS_EN is defined.
module rob_retire_stats #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic             stall_evt,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            if (retire)    retired_cnt <= retired_cnt + CNT_W'(1);
            if (stall_evt) stall_cnt   <= stall_cnt + CNT_W'(1);
            if (flush_evt) flush_cnt   <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rob_retire_ctrl.sv
// ROB head retirement sequencer: store-commit handshake, mispredict recovery, halt.
// Optional statistics counters are built when RETIRE_STATS_EN is defined.
module rob_retire_ctrl
    import rob_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter int PC_W         = 64
`ifdef RETIRE_STATS_EN
   ,parameter int CNT_W        = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rob_head_rdy_i,
    input  logic             rob_empty_i,
    input  logic             head_is_store_i,
    input  logic             head_mispred_i,
    input  logic             head_halt_i,
    input  logic [PC_W-1:0]  head_tgt_pc_i,
    input  logic             retire_stall_i,
    input  logic             st_ack_i,
    output logic             rob_retire_o,
    output logic             st_commit_o,
    output logic             rob_flush_o,
    output logic             map_restore_o,
    output logic             redirect_vld_o,
    output logic [PC_W-1:0]  redirect_pc_o,
`ifdef RETIRE_STATS_EN
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
`endif
    output logic             halt_o
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    retire_st_e      state;
    retire_st_e      state_nxt;
    logic [CW-1:0]   flush_cnt;
    logic            go;
    logic            mis_take;

    // Reset is folded in so the combinational retire strobe stays low while reset is held.
    always_comb begin
        go = rst & rob_head_rdy_i & ~rob_empty_i & ~retire_stall_i;
    end

    always_comb begin
        state_nxt    = state;
        rob_retire_o = 1'b0;
        st_commit_o  = 1'b0;
        mis_take     = 1'b0;
        case (state)
            RUN: begin
                if (go) begin
                    if (head_mispred_i) begin
                        rob_retire_o = 1'b1;
                        mis_take     = 1'b1;
                        state_nxt    = FLUSH;
                    end else if (head_is_store_i) begin
                        st_commit_o  = 1'b1;
                        state_nxt    = ST_WAIT;
                    end else if (head_halt_i) begin
                        rob_retire_o = 1'b1;
                        state_nxt    = HALTED;
                    end else begin
                        rob_retire_o = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                st_commit_o = 1'b1;
                if (st_ack_i) begin
                    rob_retire_o = 1'b1;
                    state_nxt    = RUN;
                end
            end
            FLUSH: begin
                // <= rather than == so a zero count can never strand the FSM here.
                if (flush_cnt <= CW'(1)) state_nxt = RUN;
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RUN;
            flush_cnt      <= '0;
            redirect_vld_o <= 1'b0;
            redirect_pc_o  <= '0;
        end else begin
            state          <= state_nxt;
            redirect_vld_o <= mis_take;
            if (mis_take) begin
                redirect_pc_o <= head_tgt_pc_i;
                flush_cnt     <= CW'(FLUSH_CYCLES);
            end else if (flush_cnt != '0) begin
                flush_cnt     <= flush_cnt - CW'(1);
            end
        end
    end

    assign rob_flush_o   = (state == FLUSH);
    assign map_restore_o = (state == FLUSH);
    assign halt_o        = (state == HALTED);

`ifdef RETIRE_STATS_EN
    logic stall_evt;

    assign stall_evt = (state == RUN) & rob_head_rdy_i & ~rob_empty_i & retire_stall_i;

    rob_retire_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk         (clk),
        .rst         (rst),
        .retire      (rob_retire_o),
        .stall_evt   (stall_evt),
        .flush_evt   (mis_take),
        .retired_cnt (retired_cnt_o),
        .stall_cnt   (stall_cnt_o),
        .flush_cnt   (flush_cnt_o)
    );
`endif

endmodule

// File: tb/tb_rob_retire_ctrl.sv
// Directed self-checking bench for rob_retire_ctrl; stats checks run when RETIRE_STATS_EN is defined.
module tb_rob_retire_ctrl;

    logic        clk;
    logic        rst;
    logic        rob_head_rdy_i;
    logic        rob_empty_i;
    logic        head_is_store_i;
    logic        head_mispred_i;
    logic        head_halt_i;
    logic [63:0] head_tgt_pc_i;
    logic        retire_stall_i;
    logic        st_ack_i;
    logic        rob_retire_o;
    logic        st_commit_o;
    logic        rob_flush_o;
    logic        map_restore_o;
    logic        redirect_vld_o;
    logic [63:0] redirect_pc_o;
    logic        halt_o;
`ifdef RETIRE_STATS_EN
    logic [31:0] retired_cnt_o;
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int errors = 0;
    int checks = 0;

    rob_retire_ctrl #(
        .FLUSH_CYCLES (2),
        .PC_W         (64)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rob_head_rdy_i  (rob_head_rdy_i),
        .rob_empty_i     (rob_empty_i),
        .head_is_store_i (head_is_store_i),
        .head_mispred_i  (head_mispred_i),
        .head_halt_i     (head_halt_i),
        .head_tgt_pc_i   (head_tgt_pc_i),
        .retire_stall_i  (retire_stall_i),
        .st_ack_i        (st_ack_i),
        .rob_retire_o    (rob_retire_o),
        .st_commit_o     (st_commit_o),
        .rob_flush_o     (rob_flush_o),
        .map_restore_o   (map_restore_o),
        .redirect_vld_o  (redirect_vld_o),
        .redirect_pc_o   (redirect_pc_o),
`ifdef RETIRE_STATS_EN
        .retired_cnt_o   (retired_cnt_o),
        .stall_cnt_o     (stall_cnt_o),
        .flush_cnt_o     (flush_cnt_o),
`endif
        .halt_o          (halt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle's inputs on the falling edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic rdy, input logic empty, input logic store,
                                 input logic mis, input logic halt, input logic stall,
                                 input logic ack, input logic [63:0] tgt);
        @(negedge clk);
        rob_head_rdy_i  = rdy;
        rob_empty_i     = empty;
        head_is_store_i = store;
        head_mispred_i  = mis;
        head_halt_i     = halt;
        retire_stall_i  = stall;
        st_ack_i        = ack;
        head_tgt_pc_i   = tgt;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        rob_head_rdy_i = 0; rob_empty_i = 0; head_is_store_i = 0; head_mispred_i = 0;
        head_halt_i = 0; retire_stall_i = 0; st_ack_i = 0; head_tgt_pc_i = '0;
        #2 rst = 1'b0;

        // Reset held with a ready head: everything must stay quiet.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("rst_retire",  {63'b0, rob_retire_o},   64'h0);
        checkOutput("rst_commit",  {63'b0, st_commit_o},    64'h0);
        checkOutput("rst_flush",   {63'b0, rob_flush_o},    64'h0);
        checkOutput("rst_restore", {63'b0, map_restore_o},  64'h0);
        checkOutput("rst_rvld",    {63'b0, redirect_vld_o}, 64'h0);
        checkOutput("rst_pc",      redirect_pc_o,           64'h0);
        checkOutput("rst_halt",    {63'b0, halt_o},         64'h0);
        @(negedge clk); rst = 1'b1;

        $display("[TB] plain retires");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("plain0", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("plain1", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("plain2", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("stall_c1", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 64'h0);
        checkOutput("stall_c2", {63'b0, rob_retire_o}, 64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("stall_c3", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("empty", {63'b0, rob_retire_o}, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("not_rdy", {63'b0, rob_retire_o}, 64'h0);

        $display("[TB] store commit");
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 64'h0);
        checkOutput("st0_commit", {63'b0, st_commit_o},  64'h1);
        checkOutput("st0_retire", {63'b0, rob_retire_o}, 64'h0);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1, 0, 1, 0, 0, (i == 2), 0, 64'h0);
            checkOutput("stw_commit", {63'b0, st_commit_o},  64'h1);
            checkOutput("stw_retire", {63'b0, rob_retire_o}, 64'h0);
        end
        applyStimulus(1, 0, 1, 0, 0, 0, 1, 64'h0);
        checkOutput("ack_commit", {63'b0, st_commit_o},  64'h1);
        checkOutput("ack_retire", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 64'h0);
        checkOutput("post_commit", {63'b0, st_commit_o},  64'h0);
        checkOutput("post_retire", {63'b0, rob_retire_o}, 64'h0);

        $display("[TB] mispredict recovery");
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 64'h0000_0000_0000_1040);
        checkOutput("mp_retire", {63'b0, rob_retire_o}, 64'h1);
        checkOutput("mp_flush0", {63'b0, rob_flush_o},  64'h0);
        applyStimulus(1, 0, 0, 0, 0, 1, 0, 64'h0);
        checkOutput("f1_flush",   {63'b0, rob_flush_o},    64'h1);
        checkOutput("f1_restore", {63'b0, map_restore_o},  64'h1);
        checkOutput("f1_rvld",    {63'b0, redirect_vld_o}, 64'h1);
        checkOutput("f1_pc",      redirect_pc_o,           64'h1040);
        checkOutput("f1_retire",  {63'b0, rob_retire_o},   64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("f2_flush",  {63'b0, rob_flush_o},    64'h1);
        checkOutput("f2_rvld",   {63'b0, redirect_vld_o}, 64'h0);
        checkOutput("f2_retire", {63'b0, rob_retire_o},   64'h0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("f3_flush",  {63'b0, rob_flush_o},  64'h0);
        checkOutput("f3_retire", {63'b0, rob_retire_o}, 64'h1);
        checkOutput("f3_pc",     redirect_pc_o,         64'h1040);

        $display("[TB] priority and halt");
        applyStimulus(1, 0, 1, 1, 0, 0, 0, 64'h2000);
        checkOutput("pri_retire", {63'b0, rob_retire_o}, 64'h1);
        checkOutput("pri_commit", {63'b0, st_commit_o},  64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("pri_flush",  {63'b0, rob_flush_o}, 64'h1);
        checkOutput("pri_pc",     redirect_pc_o,        64'h2000);
        checkOutput("pri_commit2", {63'b0, st_commit_o}, 64'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        applyStimulus(1, 0, 0, 0, 1, 0, 0, 64'h0);
        checkOutput("halt_retire", {63'b0, rob_retire_o}, 64'h1);
        checkOutput("halt_pre",    {63'b0, halt_o},       64'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
            checkOutput("halted_retire", {63'b0, rob_retire_o}, 64'h0);
            checkOutput("halted_halt",   {63'b0, halt_o},       64'h1);
        end

        $display("[TB] reset during flush");
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("rst2_halt", {63'b0, halt_o}, 64'h0);
        @(negedge clk); rst = 1'b1;
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 64'h3000);
        checkOutput("rf_retire", {63'b0, rob_retire_o}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("rf_rvld", {63'b0, redirect_vld_o}, 64'h1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("rf_flush_c1", {63'b0, rob_flush_o}, 64'h1);
        rst = 1'b0; #1;
        checkOutput("rf_flush",   {63'b0, rob_flush_o},    64'h0);
        checkOutput("rf_restore", {63'b0, map_restore_o},  64'h0);
        checkOutput("rf_rvld0",   {63'b0, redirect_vld_o}, 64'h0);
        checkOutput("rf_pc",      redirect_pc_o,           64'h0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
            checkOutput("rf_after_rvld",  {63'b0, redirect_vld_o}, 64'h0);
            checkOutput("rf_after_flush", {63'b0, rob_flush_o},    64'h0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 64'h0);
        checkOutput("rf_run_retire", {63'b0, rob_retire_o}, 64'h1);

`ifdef RETIRE_STATS_EN
        $display("[TB] statistics");
        @(negedge clk); rst = 1'b0; #1;
        checkOutput("cnt_rst", {32'b0, retired_cnt_o}, 64'h0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(1, 0, 0, 0, 0, (i == 2 || i == 5 || i == 9), 0, 64'h0);
        end
        applyStimulus(1, 0, 0, 1, 0, 0, 0, 64'h4000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 64'h0);
        end
        checkOutput("cnt_retired", {32'b0, retired_cnt_o}, 64'd11);
        checkOutput("cnt_stall",   {32'b0, stall_cnt_o},   64'd3);
        checkOutput("cnt_flush",   {32'b0, flush_cnt_o},   64'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
